// File: rtl/xor_stream_acc.sv
// Streaming bitwise XOR of two operand words: per-word pass mode or block checksum accumulate mode.
// Define XOR_STREAM_PARITY_EN to add an even-parity output 'par' registered alongside y.
module xor_stream_acc #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
`ifdef XOR_STREAM_PARITY_EN
    output logic             par,
`endif
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic             load_y;
    logic             block_last;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] len_eff;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign word       = a ^ b;
    assign len_eff    = (len == '0) ? ONE : len;
    assign block_last = (cnt_q == len_q - ONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && mode && (len_eff > ONE)) state_d = ACC;
            ACC:  if (accept && block_last)              state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output next-values
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        y_d    = y_q;
        load_y = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (mode && (len_eff > ONE)) begin
                        acc_d = word;
                        cnt_d = ONE;
                        len_d = len_eff;
                    end else begin
                        y_d    = word;
                        load_y = 1'b1;
                    end
                end
                ACC: begin
                    if (block_last) begin
                        y_d    = acc_q ^ word;
                        load_y = 1'b1;
                        acc_d  = '0;
                        cnt_d  = '0;
                    end else begin
                        acc_d = acc_q ^ word;
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: ;
            endcase
        end
        if (load_y) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= ONE;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef XOR_STREAM_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (load_y) begin
            par_q <= ^y_d;
        end
    end

    assign par = par_q;
`endif

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ACC);

endmodule

// File: doc/xor_stream_acc.md
Name: xor_stream_acc

Overview:
- Parametrised, registered successor to the fixed-width quad-XOR cell.
- WIDTH-bit bitwise XOR of two operand words behind a valid/ready handshake, with a one-stage output register.
- Two modes:
  - Mode 0 (pass): per-word XOR.
  - Mode 1 (accumulate): running XOR checksum over a block of `len` words; one result per block.
- Sits between bus-side word sources and checksum/compare logic in the 74xx-mapped datapath.

Parameters:
- WIDTH, 4, operand/result width in bits (>=1).
- CNT_W, 8, width of block-length field and word counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = pass, 1 = accumulate; sampled at the first accepted word of a block.
- len  input  CNT_W  words per block in accumulate mode; sampled with mode; 0 treated as 1.
- in_valid  input  1  operand word valid.
- in_ready  output  1  block can accept a word this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  y holds an unconsumed result.
- out_ready  input  1  consumer takes y this cycle.
- y  output  WIDTH  result.
- busy  output  1  accumulate block in progress (state ACC).

Behaviour:
- Reset (rst_n low, async): y=0, out_valid=0, acc=0, cnt=0, state=IDLE, busy=0. Reset mid-block discards the partial accumulation; no output is produced.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Output register: out_valid clears on (out_valid && out_ready) unless a new result loads the same cycle. A new result may load in the same cycle the old one is consumed, giving full throughput.
- States IDLE, ACC; busy = (state==ACC).
- IDLE, accept, mode=0: y <= a^b, out_valid <= 1 next edge (latency 1); stay IDLE.
- IDLE, accept, mode=1, effective len (L = max(len,1)) = 1: y <= a^b, out_valid <= 1; stay IDLE.
- IDLE, accept, mode=1, L>1:
  - acc <= a^b, cnt <= 1, latch L.
  - Go ACC. No output.
- ACC, accept:
  - If cnt == L-1: y <= acc^a^b, out_valid <= 1, acc <= 0, cnt <= 0, go IDLE.
  - Else: acc <= acc^a^b, cnt <= cnt+1.
- ACC ignores mode/len changes; they take effect at the next block.
- No accept (in_valid low or in_ready low): acc, cnt and state hold. Back-pressure never loses or duplicates a word.
- cnt width CNT_W; L up to 2^CNT_W-1. cnt never wraps because it resets at L-1.
- All XOR is bitwise, width WIDTH; no sign semantics.

Optional Feature:
- Macro XOR_STREAM_PARITY_EN.
- Defined:
  - Adds output port par (1 bit), registered with y: par <= ^(next y), 74x280-style even parity.
  - par resets to 0 and is valid when out_valid=1.
- Undefined: port par absent; no parity logic.

Test Plan:
- Reset/idle: rst_n=0 asynchronously mid-cycle -> y=0, out_valid=0, busy=0, in_ready=1 immediately.
- Pass mode, WIDTH=4: a=4'hA, b=4'h6, in_valid=1, out_ready=1 -> next cycle y=4'hC, out_valid=1. Back-to-back words produce one result per cycle.
- Accumulate, len=3: words (a,b) = (1,0), (2,0), (4,8), no stalls.
  - busy=1 after the first word.
  - Result y=4'hF, out_valid=1 one cycle after the third accept; busy=0.
- Back-pressure: out_valid=1, out_ready=0 -> in_ready=0; a, b and acc are unchanged until out_ready=1, then the pending result drains and the next word is accepted the same cycle.
- Boundaries:
  - len=0 with mode=1 -> behaves as len=1 (y=a^b).
  - rst_n pulsed after 2 of 3 words -> no output; the next block starts with acc=0.
  - Mode toggled during ACC -> ignored.
- Parity (XOR_STREAM_PARITY_EN defined): pass a=4'h7, b=4'h0 -> y=4'h7, par=1. Undefined build compiles without par.
